// File: rtl/pwl_synth_out_pkg.sv
// Shared constants for the PWL synth output stage: mode encodings and default widths.
package pwl_synth_out_pkg;

    localparam int BITS_DEF       = 12;
    localparam int FRAME_BITS_DEF = 8;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_SDM = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;

endpackage

// File: rtl/pwl_synth_sdm1.sv
// First-order sigma-delta accumulator; bit_o is the carry of the next accumulator value.
module pwl_synth_sdm1 #(
    parameter int BITS = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [BITS-1:0] u_i,
    output logic            bit_o
);

    logic [BITS:0] acc_q;
    logic [BITS:0] acc_d;

    // Disabled means held at zero so a later SDM frame starts from a clean phase.
    always_comb begin
        acc_d = '0;
        if (en_i) begin
            acc_d = {1'b0, acc_q[BITS-1:0]} + {1'b0, u_i};
        end
    end

    assign bit_o = acc_d[BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pwl_synth_dac_out.sv
// 1-bit audio output stage: one-entry sample buffer, frame timing, PWM or sigma-delta modulation.
module pwl_synth_dac_out
    import pwl_synth_out_pkg::*;
#(
    parameter int BITS       = BITS_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] sample_in,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic [1:0]      mode,
    input  logic [2:0]      vol,
    input  logic            underrun_clr,
    output logic            underrun,
    output logic            frame_start,
    output logic            audio_out
);

    logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic                  full_q, full_d;
    logic [BITS-1:0]       hold_q, hold_d;
    logic [BITS-1:0]       active_q, active_d;
    logic [1:0]            mode_q, mode_d;
    logic [2:0]            vol_q, vol_d;
    logic                  underrun_q, underrun_d;
    logic                  frame_start_q;
    logic                  audio_q, audio_d;

    logic                  boundary;
    logic                  underrun_set;
    logic signed [BITS-1:0] att;
    logic [BITS-1:0]       u_d;
    logic [FRAME_BITS-1:0] pwm_level;
    logic                  sdm_bit;

    assign boundary = &frame_cnt_q;

    always_comb begin
        frame_cnt_d  = frame_cnt_q + 1'b1;
        full_d       = full_q;
        hold_d       = hold_q;
        active_d     = active_q;
        mode_d       = mode_q;
        vol_d        = vol_q;
        underrun_set = 1'b0;
        if (boundary) begin
            mode_d = mode;
            vol_d  = vol;
            if (full_q) begin
                active_d = hold_q;
                full_d   = 1'b0;
            end else if (sample_valid) begin
                active_d = sample_in;
            end else begin
                underrun_set = 1'b1;
            end
        end else if (sample_valid && !full_q) begin
            hold_d = sample_in;
            full_d = 1'b1;
        end
        underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    end

    // Modulators look at the values that will be in effect next cycle, so the
    // output registered at the boundary already belongs to the new frame.
    always_comb begin
        att       = $signed(active_d) >>> vol_d;
        u_d       = att ^ {1'b1, {(BITS-1){1'b0}}};
        pwm_level = u_d[BITS-1 -: FRAME_BITS];
        case (mode_d)
            MODE_PWM: audio_d = pwm_level > frame_cnt_d;
            MODE_SDM: audio_d = sdm_bit;
            MODE_OFF: audio_d = 1'b0;
            default:  audio_d = 1'b0;
        endcase
    end

    pwl_synth_sdm1 #(.BITS(BITS)) u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (mode_d == MODE_SDM),
        .u_i   (u_d),
        .bit_o (sdm_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            full_q        <= 1'b0;
            hold_q        <= '0;
            active_q      <= '0;
            mode_q        <= MODE_OFF;
            vol_q         <= '0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
            audio_q       <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            full_q        <= full_d;
            hold_q        <= hold_d;
            active_q      <= active_d;
            mode_q        <= mode_d;
            vol_q         <= vol_d;
            underrun_q    <= underrun_d;
            frame_start_q <= boundary;
            audio_q       <= audio_d;
        end
    end

    assign sample_ready = !full_q;
    assign underrun     = underrun_q;
    assign frame_start  = frame_start_q;
    assign audio_out    = audio_q;

endmodule

// File: tb/tb_pwl_synth_dac_out.sv
// Directed and randomized frames for pwl_synth_dac_out, checked against a frame-level model.
module tb_pwl_synth_dac_out;
    import pwl_synth_out_pkg::*;

    localparam int FLEN = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  vol = 3'd0;
    logic        underrun_clr = 1'b0;
    logic        underrun;
    logic        frame_start;
    logic        audio_out;

    always #5 clk = ~clk;

    pwl_synth_dac_out dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mode         (mode),
        .vol          (vol),
        .underrun_clr (underrun_clr),
        .underrun     (underrun),
        .frame_start  (frame_start),
        .audio_out    (audio_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: the sample/mode/vol in force for the current frame plus the buffer.
    int          m_active = 0;
    int          m_mode = 0;
    int          m_vol = 0;
    bit          m_full = 0;
    logic [11:0] m_hold = '0;
    bit          m_under = 0;
    bit          fresh = 1;

    function automatic int sx(input logic [11:0] x);
        return x[11] ? int'(x) - 4096 : int'(x);
    endfunction

    // Offset-binary level: floor(sample / 2^vol) shifted up by half scale.
    function automatic int u_of(input int s, input int v);
        return (s >>> v) + 2048;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from frame_cnt 0 to the boundary, checking every cycle.
    task automatic run_frame(input bit push, input int ppos, input logic [11:0] pval,
                             input bit dbl, input bit byp, input logic [1:0] m,
                             input logic [2:0] v, input int cpos);
        int u, lvl, ones;
        bit pwm, sdm, set;
        u    = u_of(m_active, m_vol);
        lvl  = u / 16;
        pwm  = (m_mode == 2);
        sdm  = (m_mode == 1);
        ones = 0;
        for (int k = 0; k < FLEN; k++) begin
            ones += int'(audio_out);
            chk("frame_start", frame_start, (k == 0) && !fresh);
            chk("sample_ready", sample_ready, !m_full);
            chk("underrun", underrun, m_under);
            if (pwm) chk("pwm_bit", audio_out, lvl > k);
            else if (!sdm) chk("off_bit", audio_out, 0);

            sample_valid = 1'b0;
            underrun_clr = 1'b0;
            if (push && k == ppos) begin sample_valid = 1'b1; sample_in = pval; end
            if (push && dbl && k == ppos + 5) begin sample_valid = 1'b1; sample_in = ~pval; end
            if (byp && k == FLEN - 1) begin sample_valid = 1'b1; sample_in = pval; end
            if (k == 60) begin mode = 2'($urandom); vol = 3'($urandom); end
            if (k == 200) begin mode = m; vol = v; end
            if (k == cpos) underrun_clr = 1'b1;

            set = 0;
            if (k == FLEN - 1) begin
                if (m_full) begin m_active = sx(m_hold); m_full = 0; end
                else if (byp) m_active = sx(pval);
                else set = 1;
                m_mode = int'(m);
                m_vol  = int'(v);
                fresh  = 0;
            end else if (sample_valid && !m_full) begin
                m_full = 1;
                m_hold = sample_in;
            end
            if (set) m_under = 1;
            else if (underrun_clr) m_under = 0;
            tick();
        end
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        if (sdm) chk_range("sdm_ones", ones, lvl, (u % 16 != 0) ? lvl + 1 : lvl);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio", audio_out, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_frame_start", frame_start, 0);
        rst_n = 1'b1;

        run_frame(1, 20,  12'h000, 0, 0, MODE_PWM, 3'd0, -1);
        run_frame(1, 77,  12'h7FF, 0, 0, MODE_PWM, 3'd0, -1);
        run_frame(1, 30,  12'h800, 1, 0, MODE_PWM, 3'd0, -1);
        run_frame(1, 100, 12'h400, 0, 0, MODE_SDM, 3'd0, -1);
        run_frame(1, 150, 12'h400, 0, 0, MODE_SDM, 3'd1, -1);
        run_frame(0, 0,   12'h000, 0, 0, MODE_SDM, 3'd1, 255);
        run_frame(1, 30,  12'h123, 0, 0, MODE_PWM, 3'd0, 5);
        run_frame(0, 0,   12'h6A0, 0, 1, MODE_PWM, 3'd2, -1);
        run_frame(1, 40,  12'h7FF, 0, 0, MODE_OFF, 3'd0, -1);
        run_frame(0, 0,   12'h000, 0, 0, MODE_PWM, 3'd0, -1);

        // Mid-frame reset with the slot full, underrun set and the output high.
        for (int k = 0; k < 100; k++) begin
            sample_valid = (k == 10);
            sample_in    = 12'h155;
            tick();
        end
        sample_valid = 1'b0;
        chk("pre_rst_audio", audio_out, 1);
        chk("pre_rst_ready", sample_ready, 0);
        chk("pre_rst_underrun", underrun, 1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_audio", audio_out, 0);
        chk("async_rst_ready", sample_ready, 1);
        chk("async_rst_underrun", underrun, 0);
        chk("async_rst_frame_start", frame_start, 0);
        repeat (2) tick();
        rst_n    = 1'b1;
        m_active = 0; m_mode = 0; m_vol = 0;
        m_full   = 0; m_under = 0; fresh = 1;

        run_frame(1, 50, 12'h7FF, 0, 0, MODE_PWM, 3'd0, -1);

        for (int f = 0; f < 12; f++) begin
            bit          p, b, d;
            int          pp, cp;
            logic [11:0] pv;
            p  = ($urandom % 4) != 0;
            b  = !p && (($urandom % 2) != 0);
            d  = ($urandom % 2) != 0;
            pp = int'($urandom_range(1, 240));
            pv = 12'($urandom);
            cp = (($urandom % 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_frame(p, pp, pv, d, b, 2'($urandom), 3'($urandom), cp);
        end
        run_frame(0, 0, 12'h000, 0, 0, MODE_OFF, 3'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwl_synth_dac_out.md
# pwl_synth_dac_out

Output stage downstream of the PWL synth's multichannel ALU. It takes the signed mixed sample the synth produces and turns it into a single-bit audio stream on one output pin, using either pulse-width modulation or first-order sigma-delta modulation. A one-entry holding buffer with a valid/ready handshake decouples the synth's sample production from the fixed output frame rate. A sticky flag records underruns.

## Interface
Parameters:
- BITS, 12, sample width, two's complement
- FRAME_BITS, 8, output frame length is 2^FRAME_BITS cycles; PWM resolution; must be ≤ BITS

Ports:
- clk  in  1  system clock; one clock
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  BITS  signed sample from the synth mixer
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  holding slot is empty; a transfer occurs when valid && ready
- mode  in  2  00 off, 01 sigma-delta, 10 PWM, 11 same as 00
- vol  in  3  attenuation: arithmetic right shift of the sample by vol
- underrun_clr  in  1  clears underrun
- underrun  out  1  sticky; a frame started with no new sample available
- frame_start  out  1  one-cycle pulse when the active sample and mode are updated
- audio_out  out  1  registered 1-bit audio output

## Operation
- frame_cnt (FRAME_BITS) increments every cycle and wraps from 2^FRAME_BITS-1 to 0. The cycle where frame_cnt == max is the frame boundary.
- Holding buffer: on valid && ready, hold <= sample_in and full <= 1. sample_ready = !full.
- At the frame boundary:
  - If full: active <= hold and full <= 0.
  - Else if sample_valid: bypass. active <= sample_in; full stays 0.
  - Else: active is unchanged and underrun <= 1.
  - In all three cases, mode_q <= mode and vol_q <= vol, and frame_start pulses in the following cycle, which is frame_cnt == 0.
- Conversion (combinational from active and vol_q):
  - att = active >>> vol_q, arithmetic shift.
  - u = att ^ (1 << (BITS-1)), i.e. offset binary; BITS bits unsigned.
- Sigma-delta (mode_q == 01):
  - acc is BITS+1 bits.
  - Each cycle: acc <= {1'b0, acc[BITS-1:0]} + u, and audio_out <= acc_next[BITS].
  - The long-run density of ones is u / 2^BITS.
- PWM (mode_q == 10): audio_out <= (u[BITS-1 -: FRAME_BITS] > frame_cnt_next), so the frame contains exactly u[BITS-1 -: FRAME_BITS] high cycles.
- Off (mode_q is 00 or 11): audio_out <= 0 and acc <= 0.
- Mode and vol changes take effect only at a frame boundary. Between boundaries the input pins are ignored.
- Underrun:
  - Set has priority over underrun_clr in the same cycle.
  - Otherwise underrun_clr clears it the next cycle.

## Timing
- Reset values:
  - audio_out 0, sample_ready 1, underrun 0, frame_start 0.
  - frame_cnt 0, acc 0, full 0, active 0 (midscale output), mode_q 00, vol_q 0.
- Handshake latency: sample_ready drops the cycle after a transfer. It returns the cycle after the boundary that consumes the sample.
- audio_out is registered: one cycle of latency from frame_cnt and acc.
- The bypass path and a holding-slot write never both happen in one cycle, because the bypass requires full == 0 and no write occurs that cycle.
- A reset mid-frame returns all state to the reset values immediately (asynchronous). The frame restarts at frame_cnt 0 after rst_n is released.
- No combinational path from any input to any output except sample_valid→(none) and full→sample_ready; sample_ready is a function of a register only.

## Structure
- Package pwl_synth_out_pkg holds:
  - the mode encodings (MODE_OFF, MODE_SDM, MODE_PWM)
  - the default BITS and FRAME_BITS localparams shared with the synth top
- One natural sub-module: pwl_synth_sdm1, the first-order accumulator. It takes u and an enable and outputs the bit. The PWM comparator and the frame/buffer control stay in the top.

## Test plan
- PWM, BITS=12, FRAME_BITS=8, vol=0:
  - sample 0x000 → exactly 128 high cycles per 256-cycle frame
  - sample 0x7FF → 255 high cycles per frame
  - sample 0x800 → 0 high cycles per frame
- Sigma-delta, sample 0x400, vol=0 → u=3072; 192 ones in any aligned 256-cycle window after the first frame. With vol=1 → u=2560 and 160 ones.
- Handshake:
  - Push one sample mid-frame: sample_ready falls the next cycle and rises the cycle after the boundary.
  - A second valid while full is not accepted; hold keeps the first value.
  - A valid asserted exactly at the boundary with an empty slot is bypassed into active, with no underrun and ready staying high.
- Underrun:
  - No sample for one frame → underrun=1 at the boundary and the output repeats the previous duty cycle.
  - underrun_clr asserted in the same cycle as a new underrun → underrun stays 1.
  - A later clr alone → underrun=0.
- Mode change mid-frame from PWM to off: the PWM output continues until the boundary, then audio_out=0 from the frame_start cycle onward, and acc reads 0.
- Assert rst_n=0 mid-frame while full=1 → audio_out, underrun and full clear at once and sample_ready=1. After release the first boundary is at cycle 255.
